// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the VC-to-destination scheduler
//
// Purpose: holds the FSM state encodings, the default word geometry and the
//          eligibility helper used by demux_sched.
// Ports:   none (package)
// Config:  RR_ARB_EN is consumed by arb2, not by this package.

package demux_pkg;

  // Default word geometry
  localparam int DATA_SIZE_DEF = 10;
  localparam int DEST_BIT_DEF  = 8;
  localparam int CNT_W_DEF     = 5;

  // FSM state encodings
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;
  localparam logic [1:0] PAUSE  = 2'b10;
  localparam logic [1:0] UNUSED = 2'b11;

  // A VC may be served only if it has a word and that word's destination
  // FIFO still has room.
  function automatic logic vc_eligible(input logic empty,
                                       input logic dest_bit,
                                       input logic d0_af,
                                       input logic d1_af);
    return !empty && !(dest_bit ? d1_af : d0_af);
  endfunction

endpackage

// File: rtl/demux_sched_arb2.sv
// rtl/demux_sched_arb2.sv - two-request arbiter, fixed priority or round robin
//
// Purpose: picks at most one of two requests and returns a one-hot grant.
// Ports:   clk, reset (only with RR_ARB_EN), req[1:0] requests,
//          gnt[1:0] one-hot grant (combinational).
// Config:  RR_ARB_EN defined   -> ties alternate; the pointer is internal.
//          RR_ARB_EN undefined -> req[0] always wins a tie; no state at all.

module arb2 (
`ifdef RR_ARB_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef RR_ARB_EN
  // prio1_q=1 means req[1] wins the next tie.
  logic prio1_q;
  logic prio1_d;

  always_comb begin
    gnt     = 2'b00;
    prio1_d = prio1_q;
    if (req == 2'b11) begin
      gnt = prio1_q ? 2'b10 : 2'b01;
    end else begin
      // A lone requester is served regardless of the pointer.
      gnt = req;
    end
    // Any grant hands the next tie to the other side.
    if (gnt[0]) begin
      prio1_d = 1'b1;
    end else if (gnt[1]) begin
      prio1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio1_q <= 1'b0;
    end else begin
      prio1_q <= prio1_d;
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/demux_sched.sv
// rtl/demux_sched.sv - schedules two VC FIFO heads onto one demux output
//
// Purpose: each cycle grants at most one eligible VC, pops it, and presents
//          the word one cycle later with its destination select. Counts the
//          words delivered per destination and reports FSM/idle status.
// Ports:   clk, reset          clock, synchronous active-high reset
//          vc0_empty/vc1_empty VC FIFO empty flags
//          vc0_data/vc1_data   VC FIFO head words (first-word-fall-through)
//          d0/d1_almost_full   destination FIFO almost-full flags
//          pop_vc0/pop_vc1     combinational pops (never both set)
//          data_demux, valid_demux, dest   registered output word
//          cnt_d0, cnt_d1      wrapping per-destination word counters
//          state, idle         FSM state and drained indication
// Config:  RR_ARB_EN selects round-robin tie-breaking in arb2.

module demux_sched
  import demux_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEST_BIT  = DEST_BIT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic [DATA_SIZE-1:0] data_demux,
  output logic                 valid_demux,
  output logic                 dest,
  output logic [CNT_W-1:0]     cnt_d0,
  output logic [CNT_W-1:0]     cnt_d1,
  output logic [1:0]           state,
  output logic                 idle
);

  logic [1:0]           req;
  logic [1:0]           gnt;
  logic [DATA_SIZE-1:0] sel_word;

  logic [DATA_SIZE-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 dest_q,  dest_d;
  logic [CNT_W-1:0]     cnt0_q,  cnt0_d;
  logic [CNT_W-1:0]     cnt1_q,  cnt1_d;
  logic [1:0]           state_q, state_d;

  assign req[0] = vc_eligible(vc0_empty, vc0_data[DEST_BIT], d0_almost_full, d1_almost_full);
  assign req[1] = vc_eligible(vc1_empty, vc1_data[DEST_BIT], d0_almost_full, d1_almost_full);

  arb2 u_arb2 (
`ifdef RR_ARB_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req   (req),
    .gnt   (gnt)
  );

  // Pops are masked during reset so no word leaves a VC FIFO unrecorded.
  assign pop_vc0 = gnt[0] & ~reset;
  assign pop_vc1 = gnt[1] & ~reset;

  always_comb begin
    sel_word = '0;
    if (gnt[0]) begin
      sel_word = vc0_data;
    end else if (gnt[1]) begin
      sel_word = vc1_data;
    end
  end

  always_comb begin
    // No-grant cycles present an all-zero word.
    valid_d = |gnt;
    data_d  = sel_word;
    dest_d  = sel_word[DEST_BIT];

    // Counters follow what was actually presented, so they trail
    // valid_demux by one cycle.
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (valid_q && !dest_q) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    if (valid_q && dest_q) begin
      cnt1_d = cnt1_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      UNUSED: state_d = IDLE;
      default: begin
        if (|gnt) begin
          state_d = ACTIVE;
        end else if (vc0_empty && vc1_empty) begin
          state_d = IDLE;
        end else begin
          // Words are waiting but every head is blocked by its destination.
          state_d = PAUSE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      dest_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      state_q <= IDLE;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      dest_q  <= dest_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      state_q <= state_d;
    end
  end

  assign data_demux  = data_q;
  assign valid_demux = valid_q;
  assign dest        = dest_q;
  assign cnt_d0      = cnt0_q;
  assign cnt_d1      = cnt1_q;
  assign state       = state_q;
  assign idle        = (state_q == IDLE) && !valid_q;

endmodule

// File: tb/tb_demux_sched.sv
// tb/tb_demux_sched.sv - self-checking bench for demux_sched

module tb_demux_sched;

  localparam int DW   = 10;
  localparam int DB   = 8;
  localparam int CW   = 5;
  localparam int CMOD = 1 << CW;

  logic          clk;
  logic          reset;
  logic          vc0_empty, vc1_empty;
  logic [DW-1:0] vc0_data, vc1_data;
  logic          d0_almost_full, d1_almost_full;
  logic          pop_vc0, pop_vc1;
  logic [DW-1:0] data_demux;
  logic          valid_demux;
  logic          dest;
  logic [CW-1:0] cnt_d0, cnt_d1;
  logic [1:0]    state;
  logic          idle;

  demux_sched #(.DATA_SIZE(DW), .DEST_BIT(DB), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .data_demux     (data_demux),
    .valid_demux    (valid_demux),
    .dest           (dest),
    .cnt_d0         (cnt_d0),
    .cnt_d1         (cnt_d1),
    .state          (state),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: FIFO contents as queues, delivered-word tallies as
  // plain integers, the output word as "whatever was granted last cycle".
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            m_valid;
  int            m_data;
  bit            m_dest;
  int            m_state;
  int            m_sent0, m_sent1;
  bit            m_pref1;
  logic          last_pop0, last_pop1;

  typedef struct {
    bit       v0e, v1e, af0, af1, dd0, dd1;
    bit       ep0, ep1;
    int       est;
    bit       edest;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkword(input bit d, input logic [7:0] payload);
    logic [DW-1:0] w;
    w = '0;
    w[7:0] = payload;
    w[DB]  = d;
    return w;
  endfunction

  // One clock: drive FIFO heads, check pops against the model, cross the
  // edge, advance the model and compare every registered output.
  task automatic cycle(input logic rst);
    bit            e0, e1, g0, g1;
    logic [DW-1:0] w0, w1;
    reset     = rst;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    w0 = vc0_empty ? '0 : q0[0];
    w1 = vc1_empty ? '0 : q1[0];
    vc0_data = w0;
    vc1_data = w1;
    #1;
    e0 = !vc0_empty && !(w0[DB] ? d1_almost_full : d0_almost_full);
    e1 = !vc1_empty && !(w1[DB] ? d1_almost_full : d0_almost_full);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (e0 && e1) begin
`ifdef RR_ARB_EN
        if (m_pref1) g1 = 1'b1; else g0 = 1'b1;
`else
        g0 = 1'b1;
`endif
      end else begin
        g0 = e0;
        g1 = e1;
      end
    end
    chk("pop_vc0", int'(pop_vc0), int'(g0));
    chk("pop_vc1", int'(pop_vc1), int'(g1));
    last_pop0 = pop_vc0;
    last_pop1 = pop_vc1;
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_data = 0; m_dest = 0; m_state = 0;
      m_sent0 = 0; m_sent1 = 0; m_pref1 = 0;
    end else begin
      if (m_valid) begin
        if (m_dest) m_sent1++; else m_sent0++;
      end
      m_valid = g0 | g1;
      m_data  = g0 ? int'(w0) : (g1 ? int'(w1) : 0);
      m_dest  = g0 ? w0[DB] : (g1 ? w1[DB] : 1'b0);
      m_state = (g0 | g1) ? 1 : ((vc0_empty && vc1_empty) ? 0 : 2);
      if (g0) begin void'(q0.pop_front()); m_pref1 = 1; end
      if (g1) begin void'(q1.pop_front()); m_pref1 = 0; end
    end
    chk("valid_demux", int'(valid_demux), int'(m_valid));
    chk("data_demux", int'(data_demux), m_data);
    chk("dest", int'(dest), int'(m_dest));
    chk("cnt_d0", int'(cnt_d0), m_sent0 % CMOD);
    chk("cnt_d1", int'(cnt_d1), m_sent1 % CMOD);
    chk("state", int'(state), m_state);
    chk("idle", int'(idle), int'(m_state == 0 && !m_valid));
  endtask

  vec_t vecs[8];
  int   exp_gnt1[4];

  initial begin
    reset = 1'b1;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    m_valid = 0; m_data = 0; m_dest = 0; m_state = 0;
    m_sent0 = 0; m_sent1 = 0; m_pref1 = 0;
    last_pop0 = 0; last_pop1 = 0;

    //          v0e v1e af0 af1 dd0 dd1 ep0 ep1 est edest
    vecs[0] = '{1,  1,  0,  0,  0,  0,  0,  0,  0,  0};
    vecs[1] = '{0,  1,  0,  0,  0,  0,  1,  0,  1,  0};
    vecs[2] = '{0,  1,  0,  1,  1,  0,  0,  0,  2,  0};
    vecs[3] = '{0,  0,  0,  1,  1,  0,  0,  1,  1,  0};
    vecs[4] = '{0,  0,  0,  0,  0,  1,  1,  0,  1,  0};
    vecs[5] = '{0,  0,  1,  0,  0,  0,  0,  0,  2,  0};
    vecs[6] = '{1,  0,  0,  0,  0,  1,  0,  1,  1,  1};
    vecs[7] = '{0,  0,  1,  0,  0,  1,  0,  1,  1,  1};

    @(posedge clk);
    #1;
    cycle(1'b1);
    chk("rst_state", int'(state), 0);
    chk("rst_valid", int'(valid_demux), 0);
    chk("rst_idle", int'(idle), 1);

    // Single-cycle decisions from a freshly reset scheduler
    for (int i = 0; i < 8; i++) begin
      q0.delete(); q1.delete();
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      cycle(1'b1);
      if (!vecs[i].v0e) q0.push_back(mkword(vecs[i].dd0, 8'hA5));
      if (!vecs[i].v1e) q1.push_back(mkword(vecs[i].dd1, 8'h3C));
      d0_almost_full = vecs[i].af0;
      d1_almost_full = vecs[i].af1;
      cycle(1'b0);
      chk($sformatf("vec%0d_pop0", i), int'(last_pop0), int'(vecs[i].ep0));
      chk($sformatf("vec%0d_pop1", i), int'(last_pop1), int'(vecs[i].ep1));
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].est);
      chk($sformatf("vec%0d_valid", i), int'(valid_demux), int'(vecs[i].ep0 | vecs[i].ep1));
      chk($sformatf("vec%0d_dest", i), int'(dest), int'(vecs[i].edest));
    end

    // Three words to d0 back to back, then drain
    q0.delete(); q1.delete();
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    cycle(1'b1);
    for (int i = 0; i < 3; i++) q0.push_back(mkword(1'b0, 8'(i + 1)));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      chk("burst_pop0", int'(last_pop0), 1);
      chk("burst_valid", int'(valid_demux), 1);
      chk("burst_state", int'(state), 1);
    end
    cycle(1'b0);
    chk("burst_cnt_d0", int'(cnt_d0), 3);
    chk("burst_state_end", int'(state), 0);
    chk("burst_idle", int'(idle), 1);

    // Blocked VC0 must not hold up VC1
    q0.delete(); q1.delete();
    cycle(1'b1);
    d1_almost_full = 1'b1;
    q0.push_back(mkword(1'b1, 8'h11));
    q1.push_back(mkword(1'b0, 8'h22));
    q1.push_back(mkword(1'b0, 8'h33));
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0);
      chk("hol_pop0", int'(last_pop0), 0);
      chk("hol_pop1", int'(last_pop1), 1);
    end
    cycle(1'b0);
    chk("hol_pause", int'(state), 2);
    d1_almost_full = 1'b0;
    cycle(1'b0);
    chk("hol_release", int'(last_pop0), 1);

    // Four-cycle tie
    q0.delete(); q1.delete();
    cycle(1'b1);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mkword(1'b0, 8'(8'h40 + i)));
      q1.push_back(mkword(1'b0, 8'(8'h80 + i)));
    end
`ifdef RR_ARB_EN
    exp_gnt1 = '{0, 1, 0, 1};
`else
    exp_gnt1 = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      chk($sformatf("tie%0d_pop1", i), int'(last_pop1), exp_gnt1[i]);
    end

    // Reset right after a pop discards the registered word
    q0.delete(); q1.delete();
    cycle(1'b1);
    q0.push_back(mkword(1'b0, 8'h5A));
    cycle(1'b0);
    chk("mid_pop0", int'(last_pop0), 1);
    cycle(1'b1);
    chk("mid_valid", int'(valid_demux), 0);
    chk("mid_data", int'(data_demux), 0);
    chk("mid_cnt_d0", int'(cnt_d0), 0);
    chk("mid_state", int'(state), 0);
    cycle(1'b0);
    cycle(1'b0);
    chk("mid_cnt_after", int'(cnt_d0), 0);

    // Counter wrap: 33 words to d1
    q0.delete(); q1.delete();
    cycle(1'b1);
    for (int i = 0; i < 33; i++) q1.push_back(mkword(1'b1, 8'(i)));
    for (int i = 0; i < 36; i++) cycle(1'b0);
    chk("wrap_cnt_d1", int'(cnt_d1), 1);
    chk("wrap_cnt_d0", int'(cnt_d0), 0);

    // Random traffic against the model
    q0.delete(); q1.delete();
    cycle(1'b1);
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 6 && $urandom_range(0, 1) == 1)
        q0.push_back(mkword(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))));
      if (q1.size() < 6 && $urandom_range(0, 1) == 1)
        q1.push_back(mkword(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))));
      d0_almost_full = ($urandom_range(0, 3) == 0);
      d1_almost_full = ($urandom_range(0, 3) == 0);
      cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
